// File: rtl/sm_dbg_pkg.sv
// Shared definitions for the debug register reader: default sizes and FSM encoding.
package sm_dbg_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultAddrW = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/sm_shift_out.sv
// Loadable MSB-first shift register. Load wins over shift; zero fill on shift.
module sm_shift_out
  import sm_dbg_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  // Shift register state: parallel load, left shift, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= d;
    end else if (shift) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/sm_reg_reader.sv
// Reads one register-file entry on request and streams it out serially, MSB first.
module sm_reg_reader
  import sm_dbg_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [WIDTH-1:0]  rf_data,
  output logic              ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load, shift;

  // State, bit counter and latched address registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; the counter stops at the last bit so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StFetch;
          addr_d  = req_addr;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        load    = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        if (ser_ready) begin
          shift = 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  sm_shift_out #(
    .WIDTH (WIDTH)
  ) u_shift_out (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (rf_data),
    .msb   (ser_data)
  );

  // Outputs depend on registered state only, never on req_valid.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    ser_valid = (state_q == StShift);
    ser_last  = (state_q == StShift) && (cnt_q == CntLast);
    done      = (state_q == StDone);
    rf_addr   = addr_q;
  end

endmodule

// File: doc/sm_reg_reader.md
SM_REG_READER -- requirements
Module: sm_reg_reader

Interface
REQ-001 Parameter WIDTH, default 32, sets the register data width and the serial frame length in bits.
REQ-002 Parameter ADDR_W, default 5, sets the register index width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 req_valid  input  1  read request strobe.
REQ-006 req_ready  output  1  high when a request can be accepted.
REQ-007 req_addr  input  ADDR_W  index of the register to read.
REQ-008 rf_addr  output  ADDR_W  address driven to the register file combinational read port.
REQ-009 rf_data  input  WIDTH  register file read data, valid in the same cycle as rf_addr.
REQ-010 ser_data  output  1  serial data bit, MSB first.
REQ-011 ser_valid  output  1  ser_data is valid.
REQ-012 ser_ready  input  1  sink accepts the current bit.
REQ-013 ser_last  output  1  the current bit is the final bit (LSB) of the frame.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after the frame completes.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, SHIFT and DONE.
REQ-017 req_ready SHALL equal 1 only in IDLE; a request is accepted when req_valid && req_ready at a posedge, and req_addr SHALL be latched at that edge.
REQ-018 req_valid outside IDLE SHALL be ignored; requests are neither queued nor dropped with an error.
REQ-019 IDLE -> FETCH on accept; in FETCH, rf_addr SHALL present the latched address, and rf_data SHALL be loaded into the shift register at the end of that cycle.
REQ-020 FETCH -> SHIFT unconditionally after exactly one cycle; the first bit therefore appears 2 cycles after the accept edge.
REQ-021 In SHIFT, ser_valid SHALL be 1 and ser_data SHALL equal shift register bit WIDTH-1.
REQ-022 On each posedge with ser_valid && ser_ready, the shift register SHALL shift left by one (zero fill) and the bit counter SHALL increment.
REQ-023 With ser_ready low, ser_data, ser_last and the counter SHALL hold.
REQ-024 ser_last SHALL be 1 iff state is SHIFT and counter == WIDTH-1.
REQ-025 Acceptance of the last bit SHALL move SHIFT -> DONE; DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide, clear on entering FETCH, and never wrap within a frame.
REQ-027 rf_addr SHALL hold the latched address from FETCH until the next accept and is 0 after reset.
REQ-028 Address 0 requires no special handling; whatever rf_data returns is transmitted.
REQ-029 The minimum frame turnaround with ser_ready constantly 1 SHALL be WIDTH+3 cycles from accept to the next possible accept.

Reset
REQ-030 rst high SHALL immediately force IDLE, counter=0, shift register=0, rf_addr=0, ser_valid=0, ser_last=0, ser_data=0, busy=0 and done=0; req_ready SHALL be 1 once rst deasserts.
REQ-031 Reset mid-frame SHALL abort the frame with no further ser_valid and no done pulse.

Structure
REQ-032 State encodings (IDLE=2'd0, FETCH=2'd1, SHIFT=2'd2, DONE=2'd3) and default WIDTH/ADDR_W SHALL live in the shared package sm_dbg_pkg.
REQ-033 The loadable MSB-first shift register with hold SHALL be a separate sub-module, sm_shift_out (ports: clk, rst, load, shift, d[WIDTH], msb).
REQ-034 The block SHALL be fully synchronous apart from the async reset, with no latches and no combinational path from req_valid to any output.

Verification
REQ-035 Reset, then req_addr=5 with rf[5]=32'hA5A5_0001 and ser_ready=1 -> first bit at accept+2, 32 bits 1,0,1,0,0,1,0,1,... ending in 1; ser_last on bit 32 only; done at accept+34.
REQ-036 Same frame with ser_ready toggling 1,0 every cycle -> identical bit sequence, ser_data stable while ser_ready=0, done at accept+66.
REQ-037 req_valid held high continuously, rf[1]=32'hFFFF_FFFF -> back-to-back frames 35 cycles apart, no request accepted while busy=1.
REQ-038 rst pulsed after bit 10 of a frame -> ser_valid=0 and busy=0 immediately, no done pulse, and the next request produces a complete, correct frame.
REQ-039 req_addr=0 with rf_data=0 -> 32 zero bits, ser_last on the last bit, then a single done pulse.
